// File: rtl/fifo_pkg.sv
// Shared FIFO definitions for the write/read pointer logic.
//   ADDR_SIZE_DEF : default FIFO address width
//   depth_of()    : FIFO depth for a given address width
//   bin2gray()    : binary to reflected Gray code
//   gray2bin()    : reflected Gray code to binary
// Conversion functions work on 32-bit values; callers zero-extend
// narrower pointers and truncate the result.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE_DEF = 4;

  function automatic int unsigned depth_of(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 31; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix chain from the MSB).
//   WIDTH  : code width
//   i_gray : Gray-coded input
//   o_bin  : binary equivalent
module gray2bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  logic [WIDTH-1:0] w_bin;

  always_comb begin
    w_bin = i_gray;
    for (int unsigned i = WIDTH - 1; i > 0; i--) begin
      w_bin[i-1] = w_bin[i] ^ i_gray[i-1];
    end
  end

  assign o_bin = w_bin;

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer and full-flag logic for an asynchronous FIFO.
//   WCLK      : write clock
//   WRST_n    : asynchronous active-low reset
//   WINC      : write request
//   WQ2_RPTR  : Gray read pointer, already synchronized into WCLK
//   WOVF_CLR  : clears the sticky overflow flag
//   WPTR      : registered Gray write pointer
//   WADDR     : binary RAM write address
//   WEN       : RAM write strobe (combinational)
//   WFULL     : registered full flag
//   WAFULL    : registered almost-full flag
//   WCOUNT    : registered fill level seen by the write domain
//   WOVF      : sticky overflow (write attempted while full)
// Build option WPTR_FULL_LEVEL_EN: builds the fill-level counter and the
// almost-full comparator; without it WCOUNT is 0 and WAFULL mirrors WFULL.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = ADDR_SIZE_DEF,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                 WCLK,
  input  logic                 WRST_n,
  input  logic                 WINC,
  input  logic [ADDR_SIZE:0]   WQ2_RPTR,
  input  logic                 WOVF_CLR,
  output logic [ADDR_SIZE:0]   WPTR,
  output logic [ADDR_SIZE-1:0] WADDR,
  output logic                 WEN,
  output logic                 WFULL,
  output logic                 WAFULL,
  output logic [ADDR_SIZE:0]   WCOUNT,
  output logic                 WOVF
);

  localparam int unsigned DEPTH = depth_of(ADDR_SIZE);
  localparam int unsigned PW    = ADDR_SIZE + 1;

  if (AFULL_MARGIN < 1 || AFULL_MARGIN >= DEPTH) begin : g_bad_margin
    $error("wptr_full: AFULL_MARGIN must be in 1..DEPTH-1");
  end

  logic [ADDR_SIZE:0] r_wbin;
  logic [ADDR_SIZE:0] r_wptr;
  logic               r_wfull;
  logic               r_wovf;

  logic [ADDR_SIZE:0] w_wbinnext;
  logic [ADDR_SIZE:0] w_wgraynext;
  logic [ADDR_SIZE:0] w_rptr_full;
  logic               w_wen;
  logic               w_full_next;

  // Strobe is gated by reset so the RAM sees no write while held in reset.
  assign w_wen       = WINC & ~r_wfull & WRST_n;
  assign w_wbinnext  = r_wbin + {{ADDR_SIZE{1'b0}}, w_wen};
  assign w_wgraynext = PW'(bin2gray(32'(w_wbinnext)));

  // Full when the write pointer has lapped the read pointer exactly once:
  // in Gray code that is the two MSBs inverted, the rest equal.
  assign w_rptr_full = {~WQ2_RPTR[ADDR_SIZE:ADDR_SIZE-1], WQ2_RPTR[ADDR_SIZE-2:0]};
  assign w_full_next = (w_wgraynext == w_rptr_full);

  always_ff @(posedge WCLK or negedge WRST_n) begin
    if (!WRST_n) begin
      r_wbin  <= '0;
      r_wptr  <= '0;
      r_wfull <= 1'b0;
      r_wovf  <= 1'b0;
    end else begin
      r_wbin  <= w_wbinnext;
      r_wptr  <= w_wgraynext;
      r_wfull <= w_full_next;
      // Set wins over clear.
      r_wovf  <= (WINC & r_wfull) | (r_wovf & ~WOVF_CLR);
    end
  end

`ifdef WPTR_FULL_LEVEL_EN
  logic [ADDR_SIZE:0] w_rbin;
  logic [ADDR_SIZE:0] w_count_next;
  logic               w_afull_next;
  logic [ADDR_SIZE:0] r_wcount;
  logic               r_wafull;

  gray2bin #(
    .WIDTH(PW)
  ) u_gray2bin (
    .i_gray(WQ2_RPTR),
    .o_bin (w_rbin)
  );

  // Modulo subtraction gives the level directly across pointer wrap.
  assign w_count_next = w_wbinnext - w_rbin;
  assign w_afull_next = (32'(w_count_next) >= (DEPTH - AFULL_MARGIN));

  always_ff @(posedge WCLK or negedge WRST_n) begin
    if (!WRST_n) begin
      r_wcount <= '0;
      r_wafull <= 1'b0;
    end else begin
      r_wcount <= w_count_next;
      r_wafull <= w_afull_next;
    end
  end

  assign WCOUNT = r_wcount;
  assign WAFULL = r_wafull;
`else
  assign WCOUNT = '0;
  assign WAFULL = r_wfull;
`endif

  assign WPTR  = r_wptr;
  assign WADDR = r_wbin[ADDR_SIZE-1:0];
  assign WEN   = w_wen;
  assign WFULL = r_wfull;
  assign WOVF  = r_wovf;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ADDR_SIZE=4, AFULL_MARGIN=2).
// Reference model tracks total writes accepted and total reads as plain
// integers; fill level is their difference.
module tb_wptr_full;

  localparam int AS     = 4;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
`ifdef WPTR_FULL_LEVEL_EN
  localparam bit LEVEL_EN = 1'b1;
`else
  localparam bit LEVEL_EN = 1'b0;
`endif

  logic          WCLK = 1'b0;
  logic          WRST_n = 1'b0;
  logic          WINC = 1'b0;
  logic          WOVF_CLR = 1'b0;
  logic [AS:0]   WQ2_RPTR = '0;
  logic [AS:0]   WPTR;
  logic [AS-1:0] WADDR;
  logic          WEN;
  logic          WFULL;
  logic          WAFULL;
  logic [AS:0]   WCOUNT;
  logic          WOVF;

  wptr_full #(
    .ADDR_SIZE   (AS),
    .AFULL_MARGIN(MARGIN)
  ) dut (
    .WCLK    (WCLK),
    .WRST_n  (WRST_n),
    .WINC    (WINC),
    .WQ2_RPTR(WQ2_RPTR),
    .WOVF_CLR(WOVF_CLR),
    .WPTR    (WPTR),
    .WADDR   (WADDR),
    .WEN     (WEN),
    .WFULL   (WFULL),
    .WAFULL  (WAFULL),
    .WCOUNT  (WCOUNT),
    .WOVF    (WOVF)
  );

  always #5 WCLK = ~WCLK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int wr;
  int rd;
  int m_lvl;
  bit m_full;
  bit m_afull;
  bit m_ovf;

  function automatic logic [4:0] gray(input int v);
    int b;
    b = v & 31;
    return 5'(b ^ (b >> 1));
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [4:0] c;
    logic       af;
    c  = LEVEL_EN ? 5'(m_lvl) : 5'd0;
    af = LEVEL_EN ? m_afull : m_full;
    return {gray(wr), 4'(wr & 15), m_full, af, c, m_ovf};
  endfunction

  task automatic model_reset();
    wr = 0; m_lvl = 0; m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  task automatic drive_rd(input int v);
    rd = v;
    WQ2_RPTR = gray(v);
  endtask

  // Advance model by one write-clock edge using the inputs now applied.
  task automatic tick();
    bit acc;
    acc    = WINC && !m_full;
    m_ovf  = (WINC && m_full) || (m_ovf && !WOVF_CLR);
    wr     = wr + int'(acc);
    m_lvl  = wr - rd;
    m_full = (m_lvl == DEPTH);
    m_afull = (m_lvl >= DEPTH - MARGIN);
    @(posedge WCLK);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    WINC = 0; WOVF_CLR = 0; WRST_n = 0;
    drive_rd(0);
    @(posedge WCLK);
    #1;
    WRST_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    drive_rd(0);
    #1;
    checks++;
    if ({WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF, WEN} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF, WEN});
    end
    @(posedge WCLK);
    #1;
    WRST_n = 1;
    tick();
    checks++;
    if ({WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=%h", {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF}, exp_vec());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      WINC = 1;
      #1;
      checks++;
      if (WEN !== 1'b1 || WADDR !== 4'(i) || WPTR !== gray(i)) begin
        errors++;
        $display("FAIL fill_pre i=%0d got wen=%b addr=%0d ptr=%b exp wen=1 addr=%0d ptr=%b",
                 i, WEN, WADDR, WPTR, i, gray(i));
      end
      tick();
      checks++;
      if ({WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF} !== exp_vec()) begin
        errors++;
        $display("FAIL fill_post i=%0d got=%h exp=%h", i, {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF}, exp_vec());
      end
    end
    checks++;
    if (WFULL !== 1'b1 || WCOUNT !== (LEVEL_EN ? 5'd16 : 5'd0) || WAFULL !== 1'b1) begin
      errors++;
      $display("FAIL fill_full got full=%b count=%0d afull=%b exp full=1 count=%0d afull=1",
               WFULL, WCOUNT, WAFULL, LEVEL_EN ? 16 : 0);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      WINC = 1;
      #1;
      checks++;
      if (WEN !== 1'b0) begin
        errors++;
        $display("FAIL ovf_wen i=%0d got=%b exp=0", i, WEN);
      end
      tick();
      checks++;
      if (WPTR !== 5'b11000 || WOVF !== 1'b1 || WADDR !== 4'd0) begin
        errors++;
        $display("FAIL ovf_frozen i=%0d got ptr=%b ovf=%b addr=%0d exp ptr=11000 ovf=1 addr=0", i, WPTR, WOVF, WADDR);
      end
    end
    WINC = 1; WOVF_CLR = 1;
    tick();
    checks++;
    if (WOVF !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins got=%b exp=1", WOVF);
    end
    WINC = 0; WOVF_CLR = 1;
    tick();
    WOVF_CLR = 0;
    checks++;
    if (WOVF !== 1'b0 || {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF} !== exp_vec()) begin
      errors++;
      $display("FAIL ovf_clear got=%h exp=%h", {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF}, exp_vec());
    end
  endtask

  task automatic test_drain_one();
    WINC = 0;
    drive_rd(1);
    tick();
    checks++;
    if (WFULL !== 1'b0 || WCOUNT !== (LEVEL_EN ? 5'd15 : 5'd0)) begin
      errors++;
      $display("FAIL drain_one got full=%b count=%0d exp full=0 count=%0d", WFULL, WCOUNT, LEVEL_EN ? 15 : 0);
    end
    WINC = 1;
    #1;
    checks++;
    if (WEN !== 1'b1) begin
      errors++;
      $display("FAIL drain_wen got=%b exp=1", WEN);
    end
    tick();
    WINC = 0;
    checks++;
    if (WFULL !== 1'b1 || {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF} !== exp_vec()) begin
      errors++;
      $display("FAIL refill got=%h exp=%h", {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF}, exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    apply_reset();
    WINC = 1;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 40; i++) begin
      prev = WPTR;
      drive_rd(rd + 1);
      WINC = 1;
      tick();
      checks++;
      if ($countones(WPTR ^ prev) != 1 || WFULL !== 1'b0 ||
          WCOUNT !== (LEVEL_EN ? 5'd4 : 5'd0) ||
          {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF} !== exp_vec()) begin
        errors++;
        $display("FAIL wrap i=%0d prev=%b got=%h exp=%h", i, prev,
                 {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF}, exp_vec());
      end
    end
    WINC = 0;
  endtask

  task automatic test_reset_midburst();
    apply_reset();
    WINC = 1;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (WCOUNT !== (LEVEL_EN ? 5'd9 : 5'd0) || WADDR !== 4'd9) begin
      errors++;
      $display("FAIL midburst_level got count=%0d addr=%0d exp count=%0d addr=9", WCOUNT, WADDR, LEVEL_EN ? 9 : 0);
    end
    #2;
    WRST_n = 0;
    #1;
    checks++;
    if ({WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF, WEN} !== 18'd0) begin
      errors++;
      $display("FAIL midburst_async got=%h exp=0", {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF, WEN});
    end
    model_reset();
    @(posedge WCLK);
    #1;
    WRST_n = 1;
    #1;
    checks++;
    if (WEN !== 1'b1 || WADDR !== 4'd0) begin
      errors++;
      $display("FAIL midburst_first got wen=%b addr=%0d exp wen=1 addr=0", WEN, WADDR);
    end
    tick();
    WINC = 0;
    checks++;
    if ({WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF} !== exp_vec()) begin
      errors++;
      $display("FAIL midburst_after got=%h exp=%h", {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF}, exp_vec());
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      WINC     = ($urandom_range(0, 3) != 0);
      WOVF_CLR = ($urandom_range(0, 7) == 0);
      if (rd < wr && $urandom_range(0, 2) == 0) drive_rd(rd + 1);
      #1;
      checks++;
      if (WEN !== (WINC && !m_full)) begin
        errors++;
        $display("FAIL rand_wen i=%0d got=%b exp=%b", i, WEN, WINC && !m_full);
      end
      tick();
      checks++;
      if ({WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF} !== exp_vec()) begin
        errors++;
        $display("FAIL rand_state i=%0d got=%h exp=%h", i, {WPTR, WADDR, WFULL, WAFULL, WCOUNT, WOVF}, exp_vec());
      end
    end
    WINC = 0; WOVF_CLR = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_one();
    test_wrap();
    test_reset_midburst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
